srff_flag_arbiter: RTL
======================

# srff_flag_arbiter

Round-robin arbiter and sequencer for a shared bank of SR flag flip-flops. Several requesters issue set or clear commands against individual flags. The block grants at most one command per clock and drives one-hot set/reset strobes into the internal SR flag bank. It never asserts set and reset on the same flag in the same cycle. It sits between the control requesters and the SR flag storage and is the only writer of that storage.

## Interface
- NREQ, default 4: number of requesters (2..8).
- NFLAG, default 6: number of SR flags in the bank (1..2**IDXW).
- IDXW, default 3: flag index width per requester.

- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  reset, synchronous, active-low; sampled on rising clk.
- req  in  NREQ  request valid per requester; held high until ack.
- cmd  in  NREQ  per-requester command: 1 = set flag, 0 = clear flag.
- idx  in  NREQ*IDXW  per-requester flag index; requester i uses bits [i*IDXW +: IDXW].
- ack  out  NREQ  one-cycle grant pulse, one-hot or zero.
- err  out  1  one-cycle pulse with ack when the granted idx >= NFLAG.
- s_vec  out  NFLAG  registered one-hot set strobe into the bank.
- r_vec  out  NFLAG  registered one-hot reset strobe into the bank.
- flags  out  NFLAG  current SR flag values.

## Operation
- Reset (rst=0 at a rising edge): flags=0, ack=0, err=0, s_vec=0, r_vec=0, round-robin pointer ptr=0. Any request pending at reset is dropped.
- Eligible set each cycle: req & ~ack. A requester acked this cycle is masked, so a request still high during its ack cycle is not granted twice.
- Arbitration: search eligible requesters starting at ptr, ascending, wrapping modulo NREQ. The first hit is the winner w.
- On the edge with a winner:
  - ack[w]=1.
  - ptr=(w+1) mod NREQ.
  - If idx_w < NFLAG: s_vec=onehot(idx_w) when cmd_w=1, else r_vec=onehot(idx_w); err=0.
  - If idx_w >= NFLAG: s_vec=r_vec=0, err=1. The command is consumed and acked.
- On the edge with no winner: ack=0, err=0, s_vec=r_vec=0, ptr holds.
- Flag bank, per bit f, each edge (rst high): s_vec[f] → flags[f]=1; r_vec[f] → flags[f]=0; neither → hold. s_vec[f] and r_vec[f] are never both 1. The bank has no illegal SR state.
- Requester protocol:
  - Drive req/cmd/idx stable until ack is seen.
  - Deassert req, or present the next command, on the edge after ack.
  - Dropping req before ack withdraws the request without effect.

## Timing
- Edge k samples req/cmd/idx. At edge k, ack, err, s_vec and r_vec become valid for one cycle.
- Edge k+1 applies the strobes. flags reflects the command from edge k+1 onward. Request-to-flag latency is 2 edges.
- Throughput: one command per cycle. A lone requester that keeps req high gets acked every other cycle because of the ack mask.
- Back-to-back commands to the same flag from different requesters are applied in grant order; the last granted command wins.
- Reset mid-operation:
  - A strobe registered before the reset edge is discarded; flags go to 0, not to the strobed value.
  - The first grant after rst returns high occurs at the first edge with rst=1 and req high.
  - After reset, ptr restarts at 0.
- All outputs are registered. No combinational path from inputs to outputs.

## Test plan
- Reset: hold rst=0 for 2 cycles with req=4'b1111. Required: flags=0, ack=0, err=0, s_vec=r_vec=0 throughout. The first ack after release is ack=4'b0001.
- Single set then clear:
  - req0 with cmd=1, idx=2 → ack=4'b0001 and s_vec=6'b000100 at edge k; flags=6'b000100 at edge k+1.
  - Then req0 with cmd=0, idx=2 → r_vec=6'b000100, and flags returns to 0.
- Contention: req=4'b1111 held, with each requester deasserting after its ack and reasserting 2 cycles later. Required: grant order 0,1,2,3,0,1,…; no requester acked on consecutive edges; ptr wraps 3→0.
- Same-flag conflict: req1 sets idx=5 and req2 clears idx=5 in the same cycle, ptr=0. Required: req1 is acked first and flags[5]=1; then req2 is acked and flags[5]=0.
- Out-of-range index: req3 with idx=7 (NFLAG=6). Required: ack=4'b1000, err=1 for one cycle, s_vec=r_vec=0, flags unchanged.
- Reset mid-operation: assert rst=0 at the edge after s_vec=6'b000001. Required: flags[0] stays 0, ptr=0, and the next grant after release goes to the lowest pending requester.

Source files
------------

// File: rtl/srff_flag_arbiter_if.sv
// srff_flag_arbiter_if: requester command bus and SR flag bank strobes/state
interface srff_flag_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int NFLAG = 6,
    parameter int IDXW  = 3
);
    logic [NREQ-1:0]      req;
    logic [NREQ-1:0]      cmd;
    logic [NREQ*IDXW-1:0] idx;
    logic [NREQ-1:0]      ack;
    logic                 err;
    logic [NFLAG-1:0]     s_vec;
    logic [NFLAG-1:0]     r_vec;
    logic [NFLAG-1:0]     flags;
    modport master (output req, cmd, idx, input ack, err, s_vec, r_vec, flags);
    modport slave  (input req, cmd, idx, output ack, err, s_vec, r_vec, flags);
endinterface

// File: rtl/srff_flag_arbiter.sv
// srff_flag_arbiter: round-robin grant of set/clear commands into an SR flag bank
module srff_flag_arbiter #(
    parameter int NREQ  = 4,
    parameter int NFLAG = 6,
    parameter int IDXW  = 3
) (
    input logic clk,
    input logic rst,
    srff_flag_arbiter_if.slave bus
);
    localparam int PW = NREQ > 1 ? $clog2(NREQ) : 1;
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    w;
    logic             found;
    logic [NREQ-1:0]  elig;
    logic [IDXW-1:0]  sel_idx;
    logic             sel_cmd;
    logic             in_rng;
    logic [NFLAG-1:0] hot;
    // a requester acked last cycle is masked so its held req is not granted twice
    assign elig = bus.req & ~bus.ack;
    always_comb begin
        found = 1'b0;
        w = '0;
        for (int k = 0; k < NREQ; k++) begin
            int j;
            j = (int'(ptr) + k) % NREQ;
            if (!found && elig[j]) begin
                found = 1'b1;
                w = PW'(j);
            end
        end
    end
    assign sel_idx = bus.idx[int'(w)*IDXW +: IDXW];
    assign sel_cmd = bus.cmd[w];
    assign in_rng  = int'(sel_idx) < NFLAG;
    assign hot     = (found && in_rng) ? NFLAG'(1) << sel_idx : '0;
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr       <= '0;
            bus.ack   <= '0;
            bus.err   <= 1'b0;
            bus.s_vec <= '0;
            bus.r_vec <= '0;
            bus.flags <= '0;
        end else begin
            ptr       <= !found ? ptr : (int'(w) == NREQ - 1) ? '0 : w + 1'b1;
            bus.ack   <= found ? NREQ'(1) << w : '0;
            bus.err   <= found && !in_rng;
            bus.s_vec <= sel_cmd ? hot : '0;
            bus.r_vec <= sel_cmd ? '0 : hot;
            bus.flags <= (bus.flags | bus.s_vec) & ~bus.r_vec;
        end
    end
endmodule
